// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: memory-stall freeze, taken-branch squash and load-use bubble.
// Outputs are combinational from state and inputs; a memory stall freezes every stage and can end in a sticky bus error.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic            id_uses_rt,
  input  logic            ex_memread,
  input  logic [4:0]      ex_rt,
  input  logic            mem_branch,
  input  logic            mem_zero,
  input  logic            mem_memread,
  input  logic            mem_memwrite,
  input  logic            dmem_ready,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exmem_en,
  output logic            memwb_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exmem_flush,
  output logic            pc_src,
  output logic            dmem_req,
  output logic            bus_err,
  output logic [CNTW-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       mem_op;
  logic       freeze;
  logic       br_taken;
  logic       load_use;

  assign mem_op   = mem_memread | mem_memwrite;
  assign freeze   = (state != ERROR) && mem_op && !dmem_ready;
  assign br_taken = mem_branch & mem_zero;
  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign bus_err  = (state == ERROR);

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_src      = 1'b0;
    dmem_req    = 1'b0;
    if (rst && state != ERROR) begin
      dmem_req = mem_op;
      // A branch waiting behind a memory stall is only taken once the access completes.
      if (!freeze) begin
        if (br_taken) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
          pc_src = 1'b1;
        end else if (load_use) begin
          {idex_en, exmem_en, memwb_en} = 3'b111;
          idex_flush = 1'b1;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= RUN;
      wait_cnt     <= 8'd0;
      stall_cycles <= '0;
    end else begin
      if (!pc_en && stall_cycles != {CNTW{1'b1}})
        stall_cycles <= stall_cycles + CNTW'(1);
      case (state)
        RUN: begin
          if (freeze) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (freeze) begin
            if (wait_cnt == 8'(TIMEOUT)) state <= ERROR;
            else                          wait_cnt <= wait_cnt + 8'd1;
          end else begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end
        end
        ERROR:   state <= ERROR;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (TIMEOUT=4, CNTW=4) with an expected-value queue.
module tb_pipe_hazard_ctrl;

  localparam logic [10:0] RSTV = 11'b00000_000_0_0_0;
  localparam logic [10:0] NORM = 11'b11111_000_0_0_0;
  localparam logic [10:0] NREQ = 11'b11111_000_0_1_0;
  localparam logic [10:0] BR   = 11'b11111_111_1_0_0;
  localparam logic [10:0] BREQ = 11'b11111_111_1_1_0;
  localparam logic [10:0] LU   = 11'b00111_010_0_0_0;
  localparam logic [10:0] FRZ  = 11'b00000_000_0_1_0;
  localparam logic [10:0] ERR  = 11'b00000_000_0_0_1;

  typedef struct {
    string       tag;
    logic [10:0] ctrl;
    logic [3:0]  stall;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, mem_branch, mem_zero;
  logic       mem_memread, mem_memwrite, dmem_ready;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, pc_src, dmem_req, bus_err;
  logic [3:0] stall_cycles;
  logic [10:0] ctrl;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .pc_src(pc_src), .dmem_req(dmem_req),
    .bus_err(bus_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, pc_src, dmem_req, bus_err};

  task automatic clear_in();
    id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; ex_memread = 0;
    mem_branch = 0; mem_zero = 0; mem_memread = 0; mem_memwrite = 0; dmem_ready = 1;
  endtask

  // Queue the expectation for the inputs now applied, check it mid-cycle, then advance one clock.
  task automatic step(input string tag, input logic [10:0] c, input logic [3:0] s);
    exp_t e;
    e.tag = tag; e.ctrl = c; e.stall = s;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    assert (ctrl === e.ctrl) else begin
      n_fail++;
      $error("FAIL %s ctrl: got %b expected %b", e.tag, ctrl, e.ctrl);
    end
    n_vec++;
    assert (stall_cycles === e.stall) else begin
      n_fail++;
      $error("FAIL %s stall_cycles: got %0d expected %0d", e.tag, stall_cycles, e.stall);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    clear_in();
    @(posedge clk); #1;
    step("reset", RSTV, 4'd0);
    rst = 1'b1;

    step("normal", NORM, 4'd0);
    ex_memread = 1; ex_rt = 8; id_rs = 8;
    step("lu_rs", LU, 4'd0);
    clear_in();
    step("after_lu", NORM, 4'd1);
    ex_memread = 1; ex_rt = 5; id_rt = 5; id_uses_rt = 1;
    step("lu_rt", LU, 4'd1);
    id_uses_rt = 0;
    step("rt_unused", NORM, 4'd2);
    ex_rt = 0; id_rs = 0; id_rt = 0;
    step("lu_r0", NORM, 4'd2);
    mem_branch = 1; mem_zero = 1;
    step("branch", BR, 4'd2);
    mem_zero = 0;
    step("br_not_taken", NORM, 4'd2);
    mem_zero = 1; ex_rt = 8; id_rs = 8;
    step("br_over_lu", BR, 4'd2);

    clear_in();
    mem_memread = 1; dmem_ready = 0;
    step("rd_wait1", FRZ, 4'd2);
    step("rd_wait2", FRZ, 4'd3);
    step("rd_wait3", FRZ, 4'd4);
    dmem_ready = 1;
    step("rd_done", NREQ, 4'd5);
    clear_in();
    step("rd_after", NORM, 4'd5);

    mem_memwrite = 1; dmem_ready = 0;
    mem_branch = 1; mem_zero = 1; ex_memread = 1; ex_rt = 8; id_rs = 8;
    step("combo_wait1", FRZ, 4'd5);
    step("combo_wait2", FRZ, 4'd6);
    dmem_ready = 1;
    step("combo_done", BREQ, 4'd7);
    clear_in();
    step("combo_after", NORM, 4'd7);

    mem_memread = 1; dmem_ready = 0;
    step("abort_wait1", FRZ, 4'd7);
    step("abort_wait2", FRZ, 4'd8);
    rst = 1'b0;
    step("abort_rst", RSTV, 4'd9);
    rst = 1'b1;
    clear_in();
    step("abort_after", NORM, 4'd0);

    mem_memread = 1; dmem_ready = 0;
    for (int i = 0; i < 5; i++) step("to_wait", FRZ, 4'(i));
    dmem_ready = 1;
    for (int i = 0; i < 14; i++) step("error_hold", ERR, (5 + i > 15) ? 4'd15 : 4'(5 + i));
    rst = 1'b0;
    step("error_rst", ERR, 4'd15);
    rst = 1'b1;
    clear_in();
    step("error_after", NORM, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max MEM_WAIT cycles before error (range 1..255).
REQ-002 SHALL have parameter CNTW, default 16, width of stall_cycles counter.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 id_rs, id_rt  in  5 each  source regs of instruction in IF/ID.
REQ-006 id_uses_rt  in  1  ID instruction reads rt.
REQ-007 ex_memread  in  1  ID/EX instruction is a load; ex_rt  in  5  its destination.
REQ-008 mem_branch, mem_zero  in  1 each  EX/MEM Branch bit and Zero flag.
REQ-009 mem_memread, mem_memwrite  in  1 each  EX/MEM Memread/Memwrite bits.
REQ-010 dmem_ready  in  1  data memory completes current access this cycle.
REQ-011 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register load enables.
REQ-012 ifid_flush, idex_flush, exmem_flush  out  1 each  load bubble (all-zero control) into that register.
REQ-013 pc_src  out  1  select branch target for PC.
REQ-014 dmem_req  out  1  data memory access request.
REQ-015 bus_err  out  1  sticky memory timeout flag.
REQ-016 stall_cycles  out  CNTW  count of cycles with pc_en=0.

Function
REQ-017 SHALL implement FSM states RUN, MEM_WAIT, ERROR; outputs combinational from state and inputs.
REQ-018 mem_op = mem_memread | mem_memwrite; dmem_req SHALL = mem_op in RUN and MEM_WAIT, 0 in ERROR.
REQ-019 RUN, mem_op & !dmem_ready: all five enables 0, all flushes 0, pc_src 0; next state MEM_WAIT, wait_cnt <= 1.
REQ-020 MEM_WAIT, !dmem_ready: same freeze; wait_cnt increments; when wait_cnt = TIMEOUT, next state ERROR.
REQ-021 MEM_WAIT or RUN, dmem_ready with mem_op: access complete, behave as RUN with no memory stall this cycle; next state RUN.
REQ-022 Load-use hazard = ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
REQ-023 Branch taken = mem_branch & mem_zero.
REQ-024 No freeze, branch taken: pc_src=1, all enables 1, ifid_flush=idex_flush=exmem_flush=1 (3 wrong-path instrs squashed).
REQ-025 No freeze, no branch, load-use: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; exactly one bubble.
REQ-026 Priority: memory freeze > branch > load-use > normal (all enables 1, flushes 0, pc_src 0).
REQ-027 Branch pending during memory freeze SHALL be applied in cycle dmem_ready arrives, not before.
REQ-028 ERROR: all enables 0, flushes 0, pc_src 0, dmem_req 0, bus_err 1; exit only by reset.
REQ-029 stall_cycles SHALL increment each cycle pc_en=0 (incl. ERROR), saturate at all-ones, never wrap.
REQ-030 Flush overrides enable on same register (flushed register loads bubble).

Reset
REQ-031 rst=0 at posedge: state RUN, wait_cnt 0, stall_cycles 0, bus_err 0.
REQ-032 While rst=0: all enables 0, flushes 0, pc_src 0, dmem_req 0 (combinational, regardless of state).
REQ-033 Reset mid-MEM_WAIT or ERROR SHALL abandon access; first cycle after release is RUN.

Verification
REQ-034 ex_memread=1, ex_rt=8, id_rs=8 -> 1 cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cycles 0->1.
REQ-035 mem_branch=1, mem_zero=1 -> pc_src=1, three flushes 1 for exactly 1 cycle; ex_rt=0 load-use ignored.
REQ-036 mem_memread=1, dmem_ready low 3 cycles then high -> enables 0 for 3 cycles, 1 on 4th; state RUN after.
REQ-037 TIMEOUT=4, dmem_ready never high -> ERROR after 4 MEM_WAIT cycles, bus_err=1, dmem_req=0 until rst=0.
REQ-038 Branch taken + load-use + memwrite stall same cycle -> freeze until ready, then branch flush, no load-use bubble.
REQ-039 CNTW=4, hold freeze 20 cycles -> stall_cycles stops at 15.
